i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter: DIV, default 4, meaning clk cycles per bclk half-period; legal range 1..255.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 en  input  1  transmit enable.
REQ-005 left_channel  input  32  left sample, two's complement, valid in the cycle sample_req is high.
REQ-006 right_channel  input  32  right sample, same validity rule as left_channel.
REQ-007 sample_req  output  1  single-cycle fetch strobe, wired to the upstream stage's en.
REQ-008 bclk  output  1  I2S bit clock.
REQ-009 lrck  output  1  I2S word select: 0 = left, 1 = right.
REQ-010 sdata  output  1  I2S serial data, MSB first.

Function
REQ-011 The block SHALL have two states: IDLE and RUN.
REQ-012 In IDLE, bclk, lrck, sdata and sample_req SHALL be 0, except for the start pulse in REQ-013.
REQ-013 In IDLE with en=1, the block SHALL pulse sample_req for one cycle, latch left_channel and right_channel in that same cycle, and enter RUN on the next cycle.
REQ-014 On RUN entry, the block SHALL set bit_cnt=0, div_cnt=0 and bclk=0.
REQ-015 In RUN, div_cnt SHALL count 0..DIV-1 and wrap.
REQ-016 At each wrap of div_cnt, bclk SHALL toggle, giving a bclk period of exactly 2*DIV clk cycles.
REQ-017 A toggle of bclk from 1 to 0 is the "falling event".
REQ-018 On each falling event, bit_cnt (6 bits) SHALL advance, and sdata and lrck SHALL update in that same cycle, so outputs are stable on bclk rising edges.
REQ-019 For bit_cnt k in 0..31, sdata SHALL be latched_left[31-k].
REQ-020 For bit_cnt k in 32..63, sdata SHALL be latched_right[63-k].
REQ-021 lrck SHALL be 1 for bit_cnt 31..62 and 0 otherwise, leading the data by one bclk (standard I2S).
REQ-022 On the falling event that enters bit_cnt 63 with en=1, the block SHALL pulse sample_req for exactly one clk cycle, latch both inputs that cycle into shadow registers, and set a continue flag.
REQ-023 On the falling event that enters bit_cnt 63 with en=0, the block SHALL NOT pulse sample_req and SHALL clear the continue flag.
REQ-024 Shadow registers SHALL be copied into the shift registers when bit_cnt wraps 63->0, with the new left MSB on sdata in that cycle.
REQ-025 At the 63->0 wrap, the block SHALL continue in RUN if the continue flag is set, otherwise enter IDLE with all outputs 0.
REQ-026 In RUN, sample_req SHALL be asserted exactly once per 128*DIV clk cycles, and never in two consecutive cycles.
REQ-027 Changes of en in the middle of a frame SHALL NOT truncate the frame; only the sample at bit_cnt 63 is consulted.
REQ-028 Input data SHALL pass bit-exact; there is no rounding, sign handling or channel swap.
REQ-029 With DIV=1, bclk SHALL toggle every cycle and all rules above still hold.

Reset
REQ-030 While rst=1, the block SHALL go to IDLE and clear bclk, lrck, sdata, sample_req, div_cnt, bit_cnt, the continue flag, and the shift and shadow registers.
REQ-031 rst asserted mid-frame SHALL abort the frame on the next clk edge, with no further sample_req.
REQ-032 rst SHALL take priority over en.

Verification
REQ-033 Reset: hold rst=1 for 3 cycles with en=1 -> all outputs 0, no sample_req; release -> sample_req=1 on the first cycle after release.
REQ-034 Serialization, DIV=2, L=0x80000001, R=0x7FFFFFFE -> sdata sampled on bclk rising edges reads 1,0x30,1 | 0,1x30,0; lrck rises at bit 31 and falls at bit 63.
REQ-035 Rate: DIV=4, en held 1 for 5 frames -> sample_req pulses spaced exactly 512 clk cycles apart, bclk period 8 cycles.
REQ-036 Stop: drop en at bit_cnt 10, raise it again at bit_cnt 40, then drop it again before bit_cnt 63 -> frame completes, no sample_req at bit 63, IDLE after the wrap, outputs 0.
REQ-037 Reset mid-frame: rst pulsed at bit_cnt 45 -> outputs 0 on the next edge; restart sends the left MSB of newly fetched data.
REQ-038 DIV=1 back-to-back: L=0xAAAAAAAA, R=0x55555555 with en held 1 -> sdata toggles every bclk, and sample_req is one cycle wide every 128 cycles.

Source files
------------

// File: rtl/i2s_tx_if.sv
// Sample-fetch handshake and I2S line bundle for i2s_tx.
// master = the transmitter, slave = the upstream sample source plus the line receiver.
interface i2s_tx_if;
    logic        sample_req;
    logic [31:0] left_channel;
    logic [31:0] right_channel;
    logic        bclk;
    logic        lrck;
    logic        sdata;

    modport master (
        output sample_req,
        output bclk,
        output lrck,
        output sdata,
        input  left_channel,
        input  right_channel
    );

    modport slave (
        input  sample_req,
        input  bclk,
        input  lrck,
        input  sdata,
        output left_channel,
        output right_channel
    );
endinterface

// File: rtl/i2s_tx.sv
// I2S stereo transmitter: 64-bit frames (32-bit left then right), MSB first,
// bclk = clk / (2*DIV), next sample pair fetched one bit before the frame wraps.
module i2s_tx #(
    parameter int unsigned DIV = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    i2s_tx_if.master bus
);

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  div_cnt;
    logic [5:0]  bit_cnt;
    logic        bclk_q;
    logic        cont_q;
    logic [63:0] shift_q;
    logic [63:0] shadow_q;
    logic        sample_req;
    logic        run;
    logic        div_wrap;
    logic        fall;
    logic        enter_last;
    logic        frame_end;

    assign run        = (state_q == RUN);
    assign div_wrap   = (div_cnt == DIV_LAST);
    assign fall       = run && div_wrap && bclk_q;
    assign enter_last = fall && (bit_cnt == 6'd62);
    assign frame_end  = fall && (bit_cnt == 6'd63);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        sample_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    sample_req = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (enter_last && en) begin
                    sample_req = 1'b1;
                end
                if (frame_end && !cont_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            sample_req = 1'b0;
            state_d    = IDLE;
        end
    end

    // NOTE: non-blocking assignments keep every register reading the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: shadow and shift registers are cleared too, so an aborted frame can never replay stale samples.
            div_cnt  <= '0;
            bit_cnt  <= '0;
            bclk_q   <= 1'b0;
            cont_q   <= 1'b0;
            shift_q  <= '0;
            shadow_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    bclk_q  <= 1'b0;
                    if (sample_req) begin
                        shift_q <= {bus.left_channel, bus.right_channel};
                    end
                end
                RUN: begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        bclk_q  <= ~bclk_q;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                    // Data and word select move on the falling bclk edge so they are stable at the rising one.
                    if (fall) begin
                        bit_cnt <= bit_cnt + 6'd1;
                        if (frame_end) begin
                            shift_q <= shadow_q;
                        end else begin
                            shift_q <= {shift_q[62:0], 1'b0};
                        end
                    end
                    if (enter_last) begin
                        cont_q <= en;
                        if (sample_req) begin
                            shadow_q <= {bus.left_channel, bus.right_channel};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sample_req = sample_req;
    assign bus.bclk       = bclk_q;
    // Word select leads the data by one bit: high from the last left bit to the next-to-last right bit.
    assign bus.lrck       = run && (bit_cnt >= 6'd31) && (bit_cnt <= 6'd62);
    assign bus.sdata      = run && shift_q[63];

    a_req_single : assert property (@(posedge clk) disable iff (rst) sample_req |=> !sample_req);

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: three instances (DIV=2,4,1) exercised one at a time against a
// frame-timing model, plus literal checks of serialized words and strobe spacing.
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [31:0] l_data = 32'h8000_0001;
    logic [31:0] r_data = 32'h7FFF_FFFE;
    int          sel = 0;
    int          div_act;

    logic rst0, rst1, rst2;
    logic [3:0] a_out;
    logic a_req, a_bclk, a_lrck, a_sdata;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    int          rise_cnt = 0;
    int          last_rise = 0;
    int          rise_period = 0;
    logic        prev_bclk = 1'b0;
    logic [63:0] sd_word = '0;
    logic [63:0] lr_word = '0;
    logic [63:0] sd_frame = '0;
    logic [63:0] lr_frame = '0;
    int          req_q[$];

    logic        m_run = 1'b0;
    logic        m_cont = 1'b0;
    int          m_t = 0;
    logic [63:0] m_frame = '0;
    logic [63:0] m_next = '0;

    logic [31:0] tab_l [6] = '{32'h1234_5678, 32'hFFFF_0000, 32'h0000_0001,
                               32'h8000_0000, 32'hCAFE_F00D, 32'h0F1E_2D3C};
    logic [31:0] tab_r [6] = '{32'h9ABC_DEF0, 32'h0000_FFFF, 32'hFFFF_FFFE,
                               32'h7FFF_FFFF, 32'h1357_9BDF, 32'hA5A5_5A5A};

    i2s_tx_if bus0 ();
    i2s_tx_if bus1 ();
    i2s_tx_if bus2 ();

    assign rst0 = rst || (sel != 0);
    assign rst1 = rst || (sel != 1);
    assign rst2 = rst || (sel != 2);

    assign bus0.left_channel  = l_data;
    assign bus0.right_channel = r_data;
    assign bus1.left_channel  = l_data;
    assign bus1.right_channel = r_data;
    assign bus2.left_channel  = l_data;
    assign bus2.right_channel = r_data;

    i2s_tx #(.DIV(2)) u_div2 (.clk(clk), .rst(rst0), .en(en), .bus(bus0));
    i2s_tx #(.DIV(4)) u_div4 (.clk(clk), .rst(rst1), .en(en), .bus(bus1));
    i2s_tx #(.DIV(1)) u_div1 (.clk(clk), .rst(rst2), .en(en), .bus(bus2));

    always #5 clk = ~clk;

    assign div_act = (sel == 0) ? 2 : (sel == 1) ? 4 : 1;

    always_comb begin
        a_out = '0;
        case (sel)
            0:       a_out = {bus0.sample_req, bus0.bclk, bus0.lrck, bus0.sdata};
            1:       a_out = {bus1.sample_req, bus1.bclk, bus1.lrck, bus1.sdata};
            default: a_out = {bus2.sample_req, bus2.bclk, bus2.lrck, bus2.sdata};
        endcase
    end
    assign {a_req, a_bclk, a_lrck, a_sdata} = a_out;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h, want %0h", name, cyc, got, exp);
        end
    endtask

    // Frame-level model: a frame is 128*DIV cycles counted from its first RUN cycle.
    always @(posedge clk) begin
        if (rst) begin
            m_run <= 1'b0;
            m_t   <= 0;
        end else if (!m_run) begin
            if (en) begin
                m_run   <= 1'b1;
                m_t     <= 0;
                m_frame <= {l_data, r_data};
            end
        end else begin
            if (m_t == 126 * div_act - 1) begin
                m_cont <= en;
                if (en) m_next <= {l_data, r_data};
            end
            if (m_t == 128 * div_act - 1) begin
                if (m_cont) begin
                    m_frame <= m_next;
                    m_t     <= 0;
                end else begin
                    m_run <= 1'b0;
                end
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    initial begin
        logic [3:0] exp_o;
        int bitn;
        forever begin
            @(negedge clk);
            cyc++;
            if (!m_run) begin
                exp_o = {en && !rst, 3'b000};
            end else begin
                bitn     = m_t / (2 * div_act);
                exp_o[3] = en && !rst && (m_t == 126 * div_act - 1);
                exp_o[2] = ((m_t / div_act) % 2) == 1;
                exp_o[1] = (bitn >= 31) && (bitn <= 62);
                exp_o[0] = m_frame[63 - bitn];
            end
            check("outputs", 64'(a_out), 64'(exp_o));
            if (rst) begin
                rise_cnt  = 0;
                prev_bclk = 1'b0;
            end else begin
                if (a_bclk && !prev_bclk) begin
                    rise_cnt++;
                    sd_word = {sd_word[62:0], a_sdata};
                    lr_word = {lr_word[62:0], a_lrck};
                    if (rise_cnt == 64) begin
                        sd_frame = sd_word;
                        lr_frame = lr_word;
                    end
                    rise_period = cyc - last_rise;
                    last_rise   = cyc;
                end
                prev_bclk = a_bclk;
            end
            if (a_req) req_q.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input int target, input string tag);
        int n = 0;
        while (rise_cnt < target && n < 1000) begin
            step();
            n++;
        end
        check({tag, "_reached"}, 64'(rise_cnt >= target), 64'd1);
    endtask

    task automatic wait_req(input int count, input string tag);
        int n = 0;
        while (req_q.size() < count && n < 1000) begin
            step();
            n++;
        end
        check({tag, "_reached"}, 64'(req_q.size() >= count), 64'd1);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        step();
    endtask

    task automatic switch_to(input int s);
        step();
        rst = 1'b1;
        step();
        sel = s;
        step();
        step();
    endtask

    initial begin
        int base;
        int k;

        // Reset held three cycles with en high, then release.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold", 64'(a_out), 64'd0);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rel_req", 64'(a_req), 64'd1);
        step();
        en = 1'b0;

        // DIV=2 serialization of one frame.
        wait_rise(64, "ser");
        check("ser_sdata", sd_frame, 64'h8000_0001_7FFF_FFFE);
        check("ser_lrck", lr_frame, 64'h0000_0001_FFFF_FFFE);
        repeat (10) step();
        check("ser_idle", 64'(a_out), 64'd0);

        // Stop: en toggled mid-frame and low at bit 63.
        do_reset();
        l_data = 32'hDEAD_BEEF;
        r_data = 32'h0F0F_0F0F;
        en  = 1'b1;
        rst = 1'b0;
        base = req_q.size();
        wait_rise(11, "stop_b10");
        en = 1'b0;
        wait_rise(41, "stop_b40");
        en = 1'b1;
        wait_rise(55, "stop_b54");
        en = 1'b0;
        wait_rise(64, "stop_b63");
        repeat (8) step();
        check("stop_reqs", 64'(req_q.size() - base), 64'd1);
        check("stop_idle", 64'(a_out), 64'd0);

        // Reset mid-frame at bit 45, then restart with new data.
        do_reset();
        l_data = 32'hC000_0000;
        r_data = 32'h1234_5678;
        en  = 1'b1;
        rst = 1'b0;
        step();
        en = 1'b0;
        wait_rise(46, "rstmid_b45");
        rst = 1'b1;
        step();
        rst = 1'b0;
        l_data = 32'h7FFF_FFFF;
        r_data = 32'hA5A5_A5A5;
        en = 1'b1;
        @(negedge clk);
        check("rstmid_out", 64'({a_bclk, a_lrck, a_sdata}), 64'd0);
        check("rstmid_req", 64'(a_req), 64'd1);
        step();
        en = 1'b0;
        @(negedge clk);
        check("restart_msb", 64'(a_sdata), 64'd0);
        wait_rise(64, "restart");
        check("restart_frame", sd_frame, 64'h7FFF_FFFF_A5A5_A5A5);
        repeat (8) step();

        // DIV=4 rate over five continuous frames with fresh data each fetch.
        switch_to(1);
        base = req_q.size();
        l_data = tab_l[0];
        r_data = tab_r[0];
        en  = 1'b1;
        rst = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            step();
            k = req_q.size() - base;
            if (k >= 6) break;
            if (k > 0) begin
                l_data = tab_l[k];
                r_data = tab_r[k];
            end
        end
        check("rate_pulses", 64'(req_q.size() - base), 64'd6);
        check("bclk_period4", 64'(rise_period), 64'd8);
        if (req_q.size() >= base + 6) begin
            check("rate_first", 64'(req_q[base + 1] - req_q[base]), 64'd504);
            for (int i = 1; i < 5; i++) begin
                check("rate_gap", 64'(req_q[base + i + 1] - req_q[base + i]), 64'd512);
            end
        end
        en = 1'b0;
        repeat (520) step();
        check("rate_idle", 64'(a_out), 64'd0);

        // DIV=1 back-to-back.
        switch_to(2);
        l_data = 32'hAAAA_AAAA;
        r_data = 32'h5555_5555;
        base = req_q.size();
        en  = 1'b1;
        rst = 1'b0;
        wait_req(base + 4, "div1_req");
        check("div1_frame", sd_frame, 64'hAAAA_AAAA_5555_5555);
        check("bclk_period1", 64'(rise_period), 64'd2);
        if (req_q.size() >= base + 4) begin
            check("div1_first", 64'(req_q[base + 1] - req_q[base]), 64'd126);
            check("div1_gap_a", 64'(req_q[base + 2] - req_q[base + 1]), 64'd128);
            check("div1_gap_b", 64'(req_q[base + 3] - req_q[base + 2]), 64'd128);
        end
        en = 1'b0;
        repeat (140) step();
        check("div1_idle", 64'(a_out), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
